// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Holds the sequencing FSM encoding, register-address defaults and the multi-cycle counter width.
// No logic; imported by hazard_stall_ctrl and load_use_detect.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_e;

    localparam int REG_ADDR_W_DEF = 5;

    localparam logic [4:0] ZERO_REG = 5'd0;

    // Wide enough for MC_LAT-2 with MC_LAT up to 15
    localparam int MC_CNT_W = 4;

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the register an in-flight load will write.
// Purely combinational, zero latency; no flow control.
// Kept standalone so a branch-in-ID hazard check can reuse it.
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  lu
);

    logic dst_live;
    logic rs_hit;
    logic rt_hit;

    always_comb begin
        // Writes to $zero never create a dependency
        dst_live = ex_mem_read && (ex_rt != REG_ADDR_W'(ZERO_REG));
        rs_hit   = (ex_rt == id_rs);
        rt_hit   = id_uses_rt && (ex_rt == id_rt);
        lu       = dst_live && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, mul/div front-end freeze, taken-branch flush.
// Control outputs are combinational from state and inputs; a multi-cycle op freezes for MC_LAT cycles.
// Optional perf counters (stall/flush) are built only when HAZARD_PERF_EN is defined.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int MC_LAT     = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  mc_start,
    input  logic                  branch_taken,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_write,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  mc_busy,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    if (MC_LAT < 2 || MC_LAT > 15) begin : g_bad_mc_lat
        $error("hazard_stall_ctrl: MC_LAT must be in 2..15");
    end

    localparam logic [MC_CNT_W-1:0] MC_LOAD = MC_CNT_W'(MC_LAT - 2);

    logic                lu;
    state_e              state_q;
    state_e              state_d;
    logic [MC_CNT_W-1:0] mc_cnt_q;
    logic [MC_CNT_W-1:0] mc_cnt_d;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_lu (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .lu          (lu)
    );

    always_comb begin
        state_d     = state_q;
        mc_cnt_d    = mc_cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mc_busy     = 1'b0;

        if (rst) begin
            // Hold the whole pipeline frozen and bubbled while in reset
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (branch_taken) begin
                        // ID holds a wrong-path instruction, so its hazard is moot;
                        // a coincident mc_start is also wrong-path and is dropped
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (mc_start) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_flush = 1'b1;
                        mc_cnt_d    = MC_LOAD;
                        state_d     = MC_WAIT;
                    end else if (lu) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MC_WAIT: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_flush = 1'b1;
                    mc_busy     = 1'b1;
                    if (mc_cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        mc_cnt_d = mc_cnt_q - MC_CNT_W'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            mc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic             stall_evt;
    logic             flush_evt;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    always_comb begin
        stall_evt   = !rst && !pc_write;
        flush_evt   = !rst && (state_q == RUN) && branch_taken;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        // Saturate instead of wrapping so a long run never reads back small
        if (stall_evt && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_evt && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl with a queue-based scoreboard.
// Counter expectations apply when HAZARD_PERF_EN is defined; otherwise the counters must read 0.
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 4;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Control vector order: pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, mc_busy
    localparam logic [6:0] C_RUN = 7'b1110000;
    localparam logic [6:0] C_LU  = 7'b0010100;
    localparam logic [6:0] C_BR  = 7'b1111100;
    localparam logic [6:0] C_MCS = 7'b0000010;
    localparam logic [6:0] C_MCW = 7'b0000011;
    localparam logic [6:0] C_RST = 7'b0001110;

    typedef struct {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic       emr;
        logic [4:0] ert;
        logic       mcs;
        logic       br;
        logic [6:0] ctl;
        int         s;
        int         f;
        int         idx;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             mc_start;
    logic             branch_taken;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             mc_busy;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    hazard_stall_ctrl #(
        .REG_ADDR_W (5),
        .MC_LAT     (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .mc_start     (mc_start),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_write   (idex_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .mc_busy      (mc_busy),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input int rs, input int rt, input logic urt,
                       input logic emr, input int ert, input logic mcs, input logic br,
                       input logic [6:0] ctl, input int s, input int f);
        vec_t v;
        v.rst = r;   v.rs = 5'(rs); v.rt = 5'(rt); v.urt = urt;
        v.emr = emr; v.ert = 5'(ert); v.mcs = mcs; v.br = br;
        v.ctl = ctl; v.s = s; v.f = f; v.idx = vecs.size();
        vecs.push_back(v);
    endtask

    // Monitor: every cycle the controller presents a full set of outputs; compare mid-cycle
    initial begin
        vec_t e;
        logic [6:0] act;
        int es;
        int ef;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, mc_busy};
                es  = PERF ? e.s : 0;
                ef  = PERF ? e.f : 0;
                checks++;
                if (act === e.ctl) passes++;
                else $display("FAIL ctl vec%0d: got %b want %b", e.idx, act, e.ctl);
                checks++;
                if (stall_count === CNT_W'(es)) passes++;
                else $display("FAIL stall_count vec%0d: got %0d want %0d", e.idx, stall_count, es);
                checks++;
                if (flush_count === CNT_W'(ef)) passes++;
                else $display("FAIL flush_count vec%0d: got %0d want %0d", e.idx, flush_count, ef);
            end
        end
    end

    initial begin
        int wait_cyc;
        rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rt = '0; mc_start = 1'b0; branch_taken = 1'b0;

        //   rst rs rt urt emr ert mcs br  ctl    stall flush
        add(1, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0);   // reset state
        add(1, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0);   // idle run
        add(0, 8, 0, 0, 1, 8, 0, 0, C_LU,  0, 0);   // load-use on rs
        add(0, 8, 0, 0, 0, 8, 0, 0, C_RUN, 1, 0);   // bubble over, one stall
        add(0, 0, 0, 0, 1, 0, 0, 0, C_RUN, 1, 0);   // $zero never hazards
        add(0, 3, 9, 0, 1, 9, 0, 0, C_RUN, 1, 0);   // rt match but rt unused
        add(0, 3, 9, 1, 1, 9, 0, 0, C_LU,  1, 0);   // rt match and used
        add(0, 0, 0, 0, 0, 0, 1, 0, C_MCS, 2, 0);   // mc_start at T
        add(0, 8, 0, 0, 1, 8, 1, 1, C_MCW, 3, 0);   // T+1: branch/lu/mc ignored
        add(0, 0, 0, 0, 0, 0, 0, 0, C_MCW, 4, 0);   // T+2
        add(0, 0, 0, 0, 0, 0, 0, 0, C_MCW, 5, 0);   // T+3
        add(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 6, 0);   // T+4 released
        add(0, 8, 0, 0, 1, 8, 0, 1, C_BR,  6, 0);   // branch beats lu
        add(0, 0, 0, 0, 0, 0, 1, 1, C_BR,  6, 1);   // branch beats mc_start
        add(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 6, 2);   // dropped mc_start leaves RUN
        add(0, 0, 0, 0, 0, 0, 1, 0, C_MCS, 6, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, C_MCW, 7, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, C_MCW, 8, 2);
        add(0, 4, 0, 0, 1, 4, 0, 0, C_MCW, 9, 2);   // lu pending during freeze
        add(0, 4, 0, 0, 1, 4, 0, 0, C_LU, 10, 2);   // same lu bubbles on first RUN cycle
        add(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 11, 2);
        add(0, 0, 0, 0, 0, 0, 1, 0, C_MCS, 11, 2);  // T
        add(0, 0, 0, 0, 0, 0, 0, 0, C_MCW, 12, 2);  // T+1
        add(1, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0);   // T+2: async abort
        add(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0);   // back in RUN, counters cleared
        for (int i = 0; i < 20; i++) begin
            add(0, 7, 0, 0, 1, 7, 0, 0, C_LU, (i < 15) ? i : 15, 0);
        end
        add(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 15, 0);  // saturated at all-ones

        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            rst          = vecs[k].rst;
            id_rs        = vecs[k].rs;
            id_rt        = vecs[k].rt;
            id_uses_rt   = vecs[k].urt;
            ex_mem_read  = vecs[k].emr;
            ex_rt        = vecs[k].ert;
            mc_start     = vecs[k].mcs;
            branch_taken = vecs[k].br;
            exp_q.push_back(vecs[k]);
        end

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
